// File: rtl/regfile_scoreboard_if.sv
// Bundle between decode/writeback (master) and the register file with scoreboard (slave).
// Parameters must match those given to the regfile_scoreboard instance.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                wb_err;

  modport master (
    output rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, issue_ready, wb_err
  );

  modport slave (
    input  rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, issue_ready, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a 2-bit pending-write counter per register.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input logic             clk,
    input logic             reset,
    regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [1:0]      pend_q [NREGS];
  logic [1:0]      pend_d [NREGS];
  logic            wb_err_q, wb_err_d;

  logic issue_z, wb_z, wb_same_issue, issue_inc, wb_dec;

  assign issue_z       = ZERO_R0 && (bus.issue_addr == '0);
  assign wb_z          = ZERO_R0 && (bus.wb_addr == '0);
  assign wb_same_issue = bus.wb_valid && (bus.wb_addr == bus.issue_addr);

  // A full counter can still accept a reservation when the same register retires this cycle.
  assign bus.issue_ready = !((pend_q[bus.issue_addr] == 2'd3) && !wb_same_issue);

  assign issue_inc = bus.issue_valid && bus.issue_ready && !issue_z;
  assign wb_dec    = bus.wb_valid && !wb_z;

  // Retiring a register with nothing outstanding is a protocol error, unless it is reserved this cycle.
  assign wb_err_d = wb_err_q
                  | (wb_dec && (pend_q[bus.wb_addr] == 2'd0)
                     && !(issue_inc && (bus.issue_addr == bus.wb_addr)));

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
      logic inc_g, dec_g;
      assign inc_g = issue_inc && (bus.issue_addr == AW'(gi));
      assign dec_g = wb_dec && (bus.wb_addr == AW'(gi));
      assign pend_d[gi] =
          (inc_g && !dec_g && (pend_q[gi] != 2'd3)) ? pend_q[gi] + 2'd1 :
          (dec_g && !inc_g && (pend_q[gi] != 2'd0)) ? pend_q[gi] - 2'd1 :
                                                      pend_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      if (wb_dec) begin
        regs_q[bus.wb_addr] <= bus.wb_data;
      end
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.wb_err = wb_err_q;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr_g;
      logic            zero_g;
      logic [XLEN-1:0] stored_g;
      assign addr_g   = bus.rd_addr[gi*AW +: AW];
      assign zero_g   = ZERO_R0 && (addr_g == '0);
      assign stored_g = zero_g ? '0 : regs_q[addr_g];
`ifdef REGFILE_BYPASS_EN
      logic hit_g;
      assign hit_g = bus.wb_valid && (bus.wb_addr == addr_g) && !zero_g;
      // The retiring write is treated as done, so busy only if another write remains.
      assign bus.rd_data[gi*XLEN +: XLEN] = hit_g ? bus.wb_data : stored_g;
      assign bus.rd_busy[gi] = hit_g ? (pend_q[addr_g] > 2'd1) : (pend_q[addr_g] != 2'd0);
`else
      assign bus.rd_data[gi*XLEN +: XLEN] = stored_g;
      assign bus.rd_busy[gi] = (pend_q[addr_g] != 2'd0);
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard: stimulus pushes expected observations into a queue,
// and a negedge monitor pops and compares them against the DUT outputs for that cycle.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_R0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 0 = rd_data[port], 1 = rd_busy[port], 2 = issue_ready, 3 = wb_err
  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  bit   done_checked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = bus.rd_data[e.port*XLEN +: XLEN];
        1:       act = {31'd0, bus.rd_busy[e.port]};
        2:       act = {31'd0, bus.issue_ready};
        default: act = {31'd0, bus.wb_err};
      endcase
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s (cyc %0d): got 0x%08h, want 0x%08h", e.name, cyc, act, e.val);
      end else begin
        $display("ok   %s (cyc %0d): 0x%08h", e.name, cyc, act);
      end
    end
    if (done && !done_checked) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      end
      done_checked = 1'b1;
    end
  end

  task automatic push(int kind, int port, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.port = port; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_rd(int port, logic [31:0] data, bit busy, string name);
    push(0, port, data, {name, ".data"});
    push(1, port, {31'd0, busy}, {name, ".busy"});
  endtask

  task automatic exp_ready(bit v, string name);
    push(2, 0, {31'd0, v}, {name, ".issue_ready"});
  endtask

  task automatic exp_err(bit v, string name);
    push(3, 0, {31'd0, v}, {name, ".wb_err"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
  endtask

  task automatic set_rd(int a0, int a1);
    bus.rd_addr = {a1[4:0], a0[4:0]};
  endtask

  task automatic issue(int a);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = a[4:0];
  endtask

  task automatic wb(int a, logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a[4:0];
    bus.wb_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rd(0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state on every register and port
    exp_ready(1'b1, "reset");
    exp_err(1'b0, "reset");
    for (int a = 0; a < NREGS; a++) begin
      set_rd(a, NREGS - 1 - a);
      exp_rd(0, 32'h0, 1'b0, "reset.p0");
      exp_rd(1, 32'h0, 1'b0, "reset.p1");
      tick();
    end

    // Issue x5, observe busy, retire, observe data
    issue(5); exp_ready(1'b1, "x5.issue"); tick();
    idle(); set_rd(5, 5);
    exp_rd(0, 32'h0, 1'b1, "x5.pending.p0");
    exp_rd(1, 32'h0, 1'b1, "x5.pending.p1");
    tick();
    set_rd(0, 0); wb(5, 32'hDEADBEEF); tick();
    idle(); set_rd(5, 5);
    exp_rd(0, 32'hDEADBEEF, 1'b0, "x5.done.p0");
    exp_rd(1, 32'hDEADBEEF, 1'b0, "x5.done.p1");
    exp_err(1'b0, "x5.done");
    tick();

    // Fill x7 to three pending, then full / retire-while-full behaviour
    for (int k = 0; k < 3; k++) begin
      issue(7); exp_ready(1'b1, "x7.fill"); tick();
    end
    exp_ready(1'b0, "x7.full"); tick();
    wb(7, 32'h00000070); exp_ready(1'b1, "x7.full_wb"); tick();
    idle(); issue(7); exp_ready(1'b0, "x7.still_full"); tick();
    idle(); wb(7, 32'h00000071); tick();
    wb(7, 32'h00000072); set_rd(7, 7); exp_rd(0, 32'h00000071, 1'b1, "x7.one_left"); tick();
    wb(7, 32'h00000073); tick();
    idle();
    exp_rd(0, 32'h00000073, 1'b0, "x7.drained.p0");
    exp_rd(1, 32'h00000073, 1'b0, "x7.drained.p1");
    exp_err(1'b0, "x7.drained");
    tick();

    // Register zero is hardwired
    issue(0); exp_ready(1'b1, "x0.issue"); tick();
    idle(); wb(0, 32'h00001234); set_rd(0, 0);
    exp_rd(0, 32'h0, 1'b0, "x0.wbcycle.p0");
    tick();
    idle();
    exp_rd(0, 32'h0, 1'b0, "x0.after.p0");
    exp_rd(1, 32'h0, 1'b0, "x0.after.p1");
    exp_err(1'b0, "x0.after");
    tick();

    // Issue and retire x14 in the same cycle with nothing pending: no error, data written
    issue(14); wb(14, 32'h0E0E0E0E); tick();
    idle(); set_rd(14, 14);
    exp_rd(0, 32'h0E0E0E0E, 1'b0, "x14.same_cycle");
    exp_err(1'b0, "x14.same_cycle");
    tick();

    // x3 with one pending write retired while being read, plus x12 reserved the same cycle
    issue(3); tick();
    idle(); wb(3, 32'h11111111); tick();
    idle(); issue(3); tick();
    idle(); wb(3, 32'hA5A5A5A5); issue(12); set_rd(3, 3);
`ifdef REGFILE_BYPASS_EN
    exp_rd(0, 32'hA5A5A5A5, 1'b0, "x3.wbcycle.p0");
    exp_rd(1, 32'hA5A5A5A5, 1'b0, "x3.wbcycle.p1");
`else
    exp_rd(0, 32'h11111111, 1'b1, "x3.wbcycle.p0");
    exp_rd(1, 32'h11111111, 1'b1, "x3.wbcycle.p1");
`endif
    tick();
    idle(); set_rd(3, 12);
    exp_rd(0, 32'hA5A5A5A5, 1'b0, "x3.next");
    exp_rd(1, 32'h0, 1'b1, "x12.pending");
    tick();
    wb(12, 32'h0C0C0C0C); tick();
    idle();
    exp_rd(1, 32'h0C0C0C0C, 1'b0, "x12.done");
    exp_err(1'b0, "x12.done");
    tick();

    // Unreserved writeback: written, sticky error
    wb(9, 32'hCAFE0009); tick();
    idle(); set_rd(9, 0);
    exp_rd(0, 32'hCAFE0009, 1'b0, "x9.written");
    exp_err(1'b1, "x9.err");
    tick();
    tick();
    tick();
    exp_err(1'b1, "x9.err_held");
    tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    exp_err(1'b0, "x9.err_cleared");
    exp_rd(0, 32'h0, 1'b0, "x9.cleared");
    tick();

    // Reset mid-operation drops reservations
    issue(20); tick();
    idle(); set_rd(20, 20);
    exp_rd(0, 32'h0, 1'b1, "x20.pending");
    reset = 1'b1; tick();
    reset = 1'b0;
    exp_rd(0, 32'h0, 1'b0, "x20.after_reset");
    wb(20, 32'h20202020); tick();
    idle();
    exp_rd(0, 32'h20202020, 1'b0, "x20.written");
    exp_err(1'b1, "x20.err");
    tick();

    tick();
    done = 1'b1;
    for (int k = 0; k < 10 && !done_checked; k++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
